// File: rtl/term_pkg.sv
`default_nettype none
// ============================================================================
// Module   : term_pkg
// Purpose  : Shared state encodings, control codes and cursor helpers.
// Revision : 1.0
// ============================================================================
package term_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADDR_CYC   = 3'd1,
        DATA_CYC   = 3'd2,
        CLEAR_ADDR = 3'd3,
        CLEAR_DATA = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_HIGH  = 2'd1,
        PH_LOW   = 2'd2
    } phase_t;

    localparam logic [7:0] C_BS    = 8'h08;
    localparam logic [7:0] C_LF    = 8'h0A;
    localparam logic [7:0] C_FF    = 8'h0C;
    localparam logic [7:0] C_CR    = 8'h0D;
    localparam logic [7:0] C_SPACE = 8'h20;

    localparam int COLS = 80;
    localparam int ROWS = 25;

    localparam logic [3:0] C_RS_ADDR = 4'd0;
    localparam logic [3:0] C_RS_DATA = 4'd1;

    typedef struct packed {
        logic [4:0] row;
        logic [6:0] col;
    } cursor_t;

    function automatic logic [4:0] row_next(input logic [4:0] row);
        return (row == 5'(ROWS - 1)) ? 5'd0 : row + 5'd1;
    endfunction

    function automatic cursor_t cursor_advance(input cursor_t c);
        cursor_t n;
        n = c;
        if (c.col == 7'(COLS - 1)) begin
            n.col = 7'd0;
            n.row = row_next(c.row);
        end else begin
            n.col = c.col + 7'd1;
        end
        return n;
    endfunction

    // Display RAM address: odd/even row bit above the column.
    function automatic logic [7:0] cell_addr(input logic row_lsb, input logic [6:0] col);
        return {row_lsb, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/term_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : term_writer_if
// Purpose  : Character input handshake, peripheral bus pins and cursor status.
// Revision : 1.0
// ============================================================================
interface term_writer_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       bus_clk;
    logic       cs_n;
    logic [3:0] rs;
    logic       wren_n;
    logic [7:0] data_o;
    logic       data_oe;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic       busy;

    modport master (
        output in_valid, in_char,
        input  in_ready, bus_clk, cs_n, rs, wren_n, data_o, data_oe,
               cur_col, cur_row, busy
    );

    modport slave (
        input  in_valid, in_char,
        output in_ready, bus_clk, cs_n, rs, wren_n, data_o, data_oe,
               cur_col, cur_row, busy
    );

endinterface
`default_nettype wire

// File: rtl/bus_write_phy.sv
`default_nettype none
// ============================================================================
// Module   : bus_write_phy
// Purpose  : One three-phase peripheral write cycle (SETUP, HIGH, LOW).
// Revision : 1.0
// ============================================================================
module bus_write_phy #(
    parameter int HALF_DIV = 25
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_start,
    input  wire logic [3:0] i_rs,
    input  wire logic [7:0] i_data,
    output logic            o_done,
    output logic            o_bus_clk,
    output logic            o_cs_n,
    output logic [3:0]      o_rs,
    output logic            o_wren_n,
    output logic [7:0]      o_data,
    output logic            o_data_oe
);
    import term_pkg::*;

    localparam int              CNT_W      = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(HALF_DIV - 1);

    logic             r_active;
    phase_t           r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic             w_phase_end;

    assign w_phase_end = (r_cnt == C_CNT_LAST);
    // Done flags the last clk of LOW so the caller can restart after one idle clk.
    assign o_done      = r_active && (r_phase == PH_LOW) && w_phase_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_phase   <= PH_SETUP;
            r_cnt     <= '0;
            o_bus_clk <= 1'b0;
            o_cs_n    <= 1'b1;
            o_rs      <= 4'd0;
            o_wren_n  <= 1'b1;
            o_data    <= 8'd0;
            o_data_oe <= 1'b0;
        end else if (!r_active) begin
            if (i_start) begin
                r_active  <= 1'b1;
                r_phase   <= PH_SETUP;
                r_cnt     <= '0;
                o_cs_n    <= 1'b0;
                o_wren_n  <= 1'b0;
                o_data_oe <= 1'b1;
                o_rs      <= i_rs;
                o_data    <= i_data;
            end
        end else if (!w_phase_end) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
            case (r_phase)
                PH_SETUP: begin
                    r_phase   <= PH_HIGH;
                    o_bus_clk <= 1'b1;
                end
                PH_HIGH: begin
                    r_phase   <= PH_LOW;
                    o_bus_clk <= 1'b0;
                end
                default: begin
                    r_active  <= 1'b0;
                    r_phase   <= PH_SETUP;
                    o_cs_n    <= 1'b1;
                    o_wren_n  <= 1'b1;
                    o_data_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/term_writer.sv
`default_nettype none
// ============================================================================
// Module   : term_writer
// Purpose  : Character terminal writer: cursor tracking, control codes, clear.
// Revision : 1.0
// ============================================================================
module term_writer #(
    parameter int HALF_DIV = 25
) (
    input  wire logic   clk,
    input  wire logic   rst,
    term_writer_if.slave bus
);
    import term_pkg::*;

    state_t     r_state;
    logic       r_in_ready;
    logic       r_busy;
    logic       r_start;
    logic [3:0] r_rs;
    logic [7:0] r_wdata;
    logic [7:0] r_char;
    logic [7:0] r_clr_cnt;
    cursor_t    r_cur;
    cursor_t    r_nxt;

    logic       w_accept;
    logic       w_done;
    logic       w_bus_clk;
    logic       w_cs_n;
    logic [3:0] w_rs;
    logic       w_wren_n;
    logic [7:0] w_data;
    logic       w_data_oe;

    assign w_accept = bus.in_valid && r_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_start    <= 1'b0;
            r_rs       <= 4'd0;
            r_wdata    <= 8'd0;
            r_char     <= 8'd0;
            r_clr_cnt  <= 8'd0;
            r_cur      <= '0;
            r_nxt      <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (bus.in_char >= C_SPACE) begin
                            r_char     <= bus.in_char;
                            r_nxt      <= cursor_advance(r_cur);
                            r_start    <= 1'b1;
                            r_rs       <= C_RS_ADDR;
                            r_wdata    <= cell_addr(r_cur.row[0], r_cur.col);
                            r_state    <= ADDR_CYC;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end else begin
                            case (bus.in_char)
                                C_CR: r_cur.col <= 7'd0;
                                C_LF: r_cur.row <= row_next(r_cur.row);
                                C_BS: if (r_cur.col != 7'd0) begin
                                    r_char     <= C_SPACE;
                                    r_nxt.row  <= r_cur.row;
                                    r_nxt.col  <= r_cur.col - 7'd1;
                                    r_start    <= 1'b1;
                                    r_rs       <= C_RS_ADDR;
                                    r_wdata    <= cell_addr(r_cur.row[0], r_cur.col - 7'd1);
                                    r_state    <= ADDR_CYC;
                                    r_in_ready <= 1'b0;
                                    r_busy     <= 1'b1;
                                end
                                C_FF: begin
                                    r_clr_cnt  <= 8'd0;
                                    r_start    <= 1'b1;
                                    r_rs       <= C_RS_ADDR;
                                    r_wdata    <= 8'd0;
                                    r_state    <= CLEAR_ADDR;
                                    r_in_ready <= 1'b0;
                                    r_busy     <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ADDR_CYC: if (w_done) begin
                    r_start <= 1'b1;
                    r_rs    <= C_RS_DATA;
                    r_wdata <= r_char;
                    r_state <= DATA_CYC;
                end
                DATA_CYC: if (w_done) begin
                    r_cur      <= r_nxt;
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
                CLEAR_ADDR: if (w_done) begin
                    r_start <= 1'b1;
                    r_rs    <= C_RS_DATA;
                    r_wdata <= C_SPACE;
                    r_state <= CLEAR_DATA;
                end
                CLEAR_DATA: if (w_done) begin
                    if (r_clr_cnt == 8'hFF) begin
                        r_cur      <= '0;
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 8'd1;
                        r_start   <= 1'b1;
                        r_rs      <= C_RS_ADDR;
                        r_wdata   <= r_clr_cnt + 8'd1;
                        r_state   <= CLEAR_ADDR;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    bus_write_phy #(
        .HALF_DIV (HALF_DIV)
    ) u_phy (
        .clk       (clk),
        .rst       (rst),
        .i_start   (r_start),
        .i_rs      (r_rs),
        .i_data    (r_wdata),
        .o_done    (w_done),
        .o_bus_clk (w_bus_clk),
        .o_cs_n    (w_cs_n),
        .o_rs      (w_rs),
        .o_wren_n  (w_wren_n),
        .o_data    (w_data),
        .o_data_oe (w_data_oe)
    );

    assign bus.bus_clk  = w_bus_clk;
    assign bus.cs_n     = w_cs_n;
    assign bus.rs       = w_rs;
    assign bus.wren_n   = w_wren_n;
    assign bus.data_o   = w_data;
    assign bus.data_oe  = w_data_oe;
    assign bus.in_ready = r_in_ready;
    assign bus.busy     = r_busy;
    assign bus.cur_col  = r_cur.col;
    assign bus.cur_row  = r_cur.row;

endmodule
`default_nettype wire

// File: doc/term_writer.md
TERM_WRITER -- requirements
Module: term_writer

Interface
REQ-001 SHALL have parameter HALF_DIV, default 25, clk cycles per bus_clk half-phase (50 MHz -> 1 MHz bus).
REQ-002 SHALL have ports: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: in_valid  in  1  char offered; in_ready  out  1  char accepted when both high; in_char  in  8  character/control code.
REQ-004 SHALL have ports: bus_clk  out  1  peripheral bus clock; cs_n  out  1  chip select, active low; rs  out  4  register select; wren_n  out  1  write enable, active low.
REQ-005 SHALL have ports: data_o  out  8  write data; data_oe  out  1  data bus drive enable.
REQ-006 SHALL have ports: cur_col  out  7  cursor column 0..79; cur_row  out  5  cursor row 0..24; busy  out  1  bus sequence in progress.

Function
REQ-007 SHALL implement one bus write cycle of 3 phases, each HALF_DIV clks: SETUP (cs_n=0, bus_clk=0), HIGH (bus_clk=1, peripheral latches rs), LOW (bus_clk=0, peripheral commits data on the falling edge).
REQ-008 SHALL hold rs, data_o, wren_n=0 and data_oe=1 stable for all 3 phases of a cycle; cs_n=1, wren_n=1, data_oe=0, bus_clk=0 outside cycles.
REQ-009 SHALL insert exactly 1 idle clk (cs_n=1) between consecutive bus cycles.
REQ-010 SHALL write a character as two bus cycles: rs=0 with data={cur_row[0], cur_col}, then rs=1 with the character.
REQ-011 SHALL use FSM states IDLE, ADDR_CYC, DATA_CYC, CLEAR_ADDR, CLEAR_DATA; in_ready=1 only in IDLE and not in reset.
REQ-012 SHALL treat printable codes (0x20..0xFF): IDLE->ADDR_CYC->DATA_CYC->IDLE, then advance the cursor.
REQ-013 SHALL advance the cursor as: col<79 -> col+1; col=79 -> col=0, row+1; row 24 wraps to 0.
REQ-014 SHALL handle 0x0D (CR): col=0, no bus cycles, stay in IDLE.
REQ-015 SHALL handle 0x0A (LF): row+1 with wrap 24->0, col unchanged, no bus cycles.
REQ-016 SHALL handle 0x08 (BS): if col>0, col-1 then write 0x20 at the new position; if col=0, no-op.
REQ-017 SHALL handle 0x0C (FF): write 0x20 to addresses 0x00..0xFF ascending (512 bus cycles, CLEAR_ADDR/CLEAR_DATA loop, 8-bit counter), then cursor (0,0).
REQ-018 SHALL accept and discard other codes 0x00..0x1F with no bus cycles.
REQ-019 SHALL update the cursor one clk after the final bus cycle of an operation ends, and raise in_ready in that same clk.
REQ-020 SHALL drive busy=1 from acceptance of an operation that needs bus cycles until the clk in_ready returns high.
REQ-021 SHALL ignore in_valid while in_ready=0; in_char SHALL be captured on acceptance and need not be held.

Reset
REQ-022 SHALL on rst=1 set cs_n=1, wren_n=1, data_oe=0, bus_clk=0, rs=0, data_o=0, cur_col=0, cur_row=0, busy=0, in_ready=0, state IDLE, all counters 0.
REQ-023 SHALL abort any in-flight bus cycle or clear at the first clk edge with rst=1, with no further bus_clk edges.
REQ-024 SHALL raise in_ready the first clk after rst deasserts.

Structure
REQ-025 SHALL place state encoding, control-code constants (0x08, 0x0A, 0x0C, 0x0D, 0x20), COLS=80 and ROWS=25 in shared package term_pkg.
REQ-026 SHALL implement REQ-007..009 in one sub-module bus_write_phy (start, rs, data in; done pulse out; bus pins out), which SHALL be the only driver of the bus pins.

Verification
REQ-027 SHALL cover: HALF_DIV=2, send 0x41 at reset cursor -> cycles rs=0/data 0x00 then rs=1/data 0x41, each 6 clks, 1 idle clk between, cursor (1,0).
REQ-028 SHALL cover: cursor (79,0), send 0x42 -> data 0x4F then 0x42; cursor (0,1); then 0x43 -> address 0x80.
REQ-029 SHALL cover: cursor (0,24) send 0x0A -> row 0, no cs_n activity; send 0x08 at col 0 -> no bus activity, in_ready high next clk.
REQ-030 SHALL cover: cursor (5,3) send 0x08 -> address 0x84, data 0x20, cursor (4,3).
REQ-031 SHALL cover: send 0x0C -> 512 cycles, addresses 0x00..0xFF each followed by 0x20, in_ready low throughout, cursor (0,0) at end.
REQ-032 SHALL cover: assert rst during the HIGH phase -> next clk cs_n=1, bus_clk=0, data_oe=0, cursor (0,0), in_ready=1 one clk after release.
